// File: rtl/sys1_input_cond.sv
// rtl/sys1_input_cond.sv - System 1 input conditioning: sync, debounce, coin pulse shaping, pause toggle, INP0..2 packing.
// Define SYS1_INPUT_DEBOUNCE_EN to enable the sampled debouncer; otherwise bits are used straight after the 2-FF sync.
module sys1_input_cond #(
    parameter int DEB_CYCLES  = 4800,
    parameter int COIN_FRAMES = 3,
    parameter int COIN_GAP    = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] joy,
    input  logic [7:0]  sysmode,
    input  logic [7:0]  spin,
    input  logic [2:0]  mouse_btn,
    input  logic        vs,
    output logic [7:0]  inp0,
    output logic [7:0]  inp1,
    output logic [7:0]  inp2,
    output logic        pause_out
);

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_PULSE = 2'd1,
        C_GAP   = 2'd2
    } coin_state_t;

    logic [1:0]  rst_sync;
    logic        rst_n;
    logic [16:0] sync1;
    logic [16:0] sync2;
    logic [15:0] deb;
    logic        vs_d;
    logic        frame_tick;
    logic        coin_prev;
    logic        coin_edge;
    logic        pause_prev;
    logic        coin_act;
    logic        trig_any;
    logic [7:0]  pk01;
    logic [7:0]  pk2;
    logic [7:0]  fcnt;
    coin_state_t state;
    coin_state_t state_nxt;
    logic        unused_ok;

    assign unused_ok = ^{joy[15:13], sysmode[7:6], sysmode[4], sysmode[2:0]};

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {vs, mouse_btn, joy[12:0]};
            sync2 <= sync1;
        end
    end

`ifdef SYS1_INPUT_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] smp_cnt;
    logic          deb_tick;
    logic [15:0]   smp_prev;
    logic [15:0]   agree;
    logic [15:0]   deb_q;

    assign deb_tick = (smp_cnt == CW'(DEB_CYCLES - 1));
    assign agree    = ~(sync2[15:0] ^ smp_prev);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)        smp_cnt <= '0;
        else if (deb_tick) smp_cnt <= '0;
        else               smp_cnt <= smp_cnt + 1'b1;
    end

    // A bit only moves when two consecutive samples agree, so one-sample glitches are discarded.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            smp_prev <= '0;
            deb_q    <= '0;
        end else if (deb_tick) begin
            smp_prev <= sync2[15:0];
            deb_q    <= (agree & sync2[15:0]) | (~agree & deb_q);
        end
    end
    assign deb = deb_q;
`else
    assign deb = sync2[15:0];
`endif

    assign frame_tick = sync2[16] & ~vs_d;
    assign coin_edge  = deb[11] & ~coin_prev;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            vs_d       <= 1'b0;
            coin_prev  <= 1'b0;
            pause_prev <= 1'b0;
            pause_out  <= 1'b0;
        end else begin
            vs_d       <= sync2[16];
            coin_prev  <= deb[11];
            pause_prev <= deb[12];
            if (deb[12] && !pause_prev) pause_out <= ~pause_out;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= C_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            C_IDLE:  if (coin_edge) state_nxt = C_PULSE;
            C_PULSE: if (frame_tick && fcnt == 8'(COIN_FRAMES - 1)) state_nxt = C_GAP;
            C_GAP:   if (frame_tick && fcnt == 8'(COIN_GAP - 1))    state_nxt = C_IDLE;
            default: state_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        coin_act = (state == C_PULSE);
    end

    // Counter restarts on every state change, so a tick coinciding with IDLE->PULSE is not counted.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)                          fcnt <= '0;
        else if (state != state_nxt)         fcnt <= '0;
        else if (frame_tick && state != C_IDLE) fcnt <= fcnt + 1'b1;
    end

    always_comb begin
        trig_any = deb[4] | (|deb[15:13]);
        pk01     = 8'h00;
        pk2      = 8'h00;
        if (sysmode[5]) begin
            pk01 = spin;
            pk2  = {trig_any, trig_any, deb[10], deb[9], 3'b000, coin_act};
        end else if (sysmode[3]) begin
            pk01 = {deb[1], deb[0], deb[3], deb[2], deb[5], deb[4], deb[7], deb[6]};
            pk2  = {deb[8], deb[8], deb[10], deb[9], 3'b000, coin_act};
        end else begin
            pk01 = {deb[1], deb[0], deb[3], deb[2], 1'b0, deb[5], deb[4], deb[6]};
            pk2  = {2'b00, deb[10], deb[9], 3'b000, coin_act};
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            inp0 <= 8'hFF;
            inp1 <= 8'hFF;
            inp2 <= 8'hFF;
        end else begin
            inp0 <= ~pk01;
            inp1 <= ~pk01;
            inp2 <= ~pk2;
        end
    end

endmodule

// File: tb/tb_sys1_input_cond.sv
// tb/tb_sys1_input_cond.sv - self-checking bench for sys1_input_cond: vector table, random model compare, coin/pause/reset sequences.
`timescale 1ns/1ps
module tb_sys1_input_cond;

    localparam int DEB   = 16;
    localparam int FRAME = 200;
`ifdef SYS1_INPUT_DEBOUNCE_EN
    localparam int SETTLE = 3 * DEB + 8;
`else
    localparam int SETTLE = 8;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [15:0] joy;
    logic [7:0]  sysmode;
    logic [7:0]  spin;
    logic [2:0]  mouse_btn;
    logic        vs = 1'b0;
    logic [7:0]  inp0, inp1, inp2;
    logic        pause_out;

    int checks = 0;
    int failures = 0;
    int coin_pulses = 0;
    int low_frames = 0;
    logic prev_c = 1'b1;
    logic vs_prev_m = 1'b0;

    typedef struct {
        logic [7:0]  sm;
        logic [15:0] j;
        logic [7:0]  sp;
        logic [2:0]  mb;
        logic [7:0]  e01;
        logic [7:0]  e2;
    } vec_t;

    vec_t vecs[10];

    sys1_input_cond #(.DEB_CYCLES(DEB), .COIN_FRAMES(3), .COIN_GAP(3)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .joy       (joy),
        .sysmode   (sysmode),
        .spin      (spin),
        .mouse_btn (mouse_btn),
        .vs        (vs),
        .inp0      (inp0),
        .inp1      (inp1),
        .inp2      (inp2),
        .pause_out (pause_out)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        forever begin
            repeat (FRAME - 4) @(posedge clk_sys);
            #2 vs = 1'b1;
            repeat (4) @(posedge clk_sys);
            #2 vs = 1'b0;
        end
    end

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (prev_c && !inp2[0]) coin_pulses++;
            if (vs && !vs_prev_m && !inp2[0]) low_frames++;
        end
        prev_c    = inp2[0];
        vs_prev_m = vs;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_coin(input logic lvl, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk_sys);
            if (inp2[0] === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic align_frame();
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge clk_sys);
            if (vs) break;
        end
        tick(5);
    endtask

    // Reference packing: {inp0/inp1, inp2} from the named joystick fields.
    function automatic logic [15:0] model(input logic [7:0] sm, input logic [15:0] j,
                                          input logic [7:0] sp, input logic [2:0] mb, input logic coin);
        logic up, dn, lf, rt, ru, rd, rl, rr, t1, t2, t3, t8, st1, st2, t;
        logic [7:0] a, b;
        up = j[3]; dn = j[2]; lf = j[1]; rt = j[0];
        ru = j[7]; rd = j[6]; rl = j[5]; rr = j[4];
        t1 = j[4]; t2 = j[5]; t3 = j[6]; t8 = j[8];
        st1 = j[9]; st2 = j[10];
        t = t1 | (mb != 3'b000);
        if (sm[5]) begin
            a = sp;
            b = {t, t, st2, st1, 3'b000, coin};
        end else if (sm[3]) begin
            a = {lf, rt, up, dn, rl, rr, ru, rd};
            b = {t8, t8, st2, st1, 3'b000, coin};
        end else begin
            a = {lf, rt, up, dn, 1'b0, t2, t1, t3};
            b = {2'b00, st2, st1, 3'b000, coin};
        end
        return {~a, ~b};
    endfunction

    initial begin
        bit ok;
        bit stable;
        int p0, l0;
        logic [15:0] exp;

        vecs[0] = '{8'h00, 16'h0001, 8'h00, 3'b000, 8'hBF, 8'hFF};
        vecs[1] = '{8'h00, 16'h0008, 8'h00, 3'b000, 8'hDF, 8'hFF};
        vecs[2] = '{8'h00, 16'h0070, 8'h00, 3'b000, 8'hF8, 8'hFF};
        vecs[3] = '{8'h00, 16'h0600, 8'h00, 3'b000, 8'hFF, 8'hCF};
        vecs[4] = '{8'h08, 16'h0090, 8'h00, 3'b000, 8'hF9, 8'hFF};
        vecs[5] = '{8'h08, 16'h0102, 8'h00, 3'b000, 8'h7F, 8'h3F};
        vecs[6] = '{8'h20, 16'h0000, 8'h5A, 3'b001, 8'hA5, 8'h3F};
        vecs[7] = '{8'h28, 16'h0010, 8'h00, 3'b000, 8'hFF, 8'h3F};
        vecs[8] = '{8'h20, 16'h0400, 8'hFF, 3'b000, 8'h00, 8'hDF};
        vecs[9] = '{8'hD7, 16'h0004, 8'h00, 3'b000, 8'hEF, 8'hFF};

        reset_n = 1'b0; joy = 16'hFFFF; sysmode = 8'h00; spin = 8'h00; mouse_btn = 3'b000;
        tick(3);
        chk("reset_inp0", {24'd0, inp0}, 32'hFF);
        chk("reset_inp1", {24'd0, inp1}, 32'hFF);
        chk("reset_inp2", {24'd0, inp2}, 32'hFF);
        chk("reset_pause", {31'd0, pause_out}, 32'd0);
        reset_n = 1'b1;
        tick(1);
        chk("post_reset_inp0", {24'd0, inp0}, 32'hFF);
        chk("post_reset_inp2", {24'd0, inp2}, 32'hFF);
        chk("post_reset_pause", {31'd0, pause_out}, 32'd0);
        joy = 16'h0000;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(SETTLE);

        for (int i = 0; i < 10; i++) begin
            sysmode = vecs[i].sm; joy = vecs[i].j; spin = vecs[i].sp; mouse_btn = vecs[i].mb;
            tick(SETTLE);
            chk($sformatf("vec%0d_inp0", i), {24'd0, inp0}, {24'd0, vecs[i].e01});
            chk($sformatf("vec%0d_inp1", i), {24'd0, inp1}, {24'd0, vecs[i].e01});
            chk($sformatf("vec%0d_inp2", i), {24'd0, inp2}, {24'd0, vecs[i].e2});
        end

        sysmode = 8'h00; joy = 16'h0001; spin = 8'h00; mouse_btn = 3'b000;
        tick(SETTLE);
        chk("glitch_pre", {24'd0, inp0}, 32'hBF);
        joy = 16'h0003;
        tick(1);
        joy = 16'h0001;
        stable = 1'b1;
        for (int i = 0; i < SETTLE; i++) begin
            @(negedge clk_sys);
            if (inp0 !== 8'hBF) stable = 1'b0;
        end
`ifdef SYS1_INPUT_DEBOUNCE_EN
        chk("glitch_stable", {31'd0, stable}, 32'd1);
`endif
        chk("glitch_post", {24'd0, inp0}, 32'hBF);

        for (int i = 0; i < 30; i++) begin
            sysmode = 8'($urandom);
            joy = 16'($urandom) & 16'hE7FF;
            spin = 8'($urandom);
            mouse_btn = 3'($urandom);
            tick(SETTLE);
            exp = model(sysmode, joy, spin, mouse_btn, 1'b0);
            chk($sformatf("rand%0d_inp0", i), {24'd0, inp0}, {24'd0, exp[15:8]});
            chk($sformatf("rand%0d_inp1", i), {24'd0, inp1}, {24'd0, exp[15:8]});
            chk($sformatf("rand%0d_inp2", i), {24'd0, inp2}, {24'd0, exp[7:0]});
        end

        sysmode = 8'h00; joy = 16'h0000; spin = 8'h00; mouse_btn = 3'b000;
        tick(SETTLE);
        align_frame();
        p0 = coin_pulses; l0 = low_frames;
        joy = 16'h0800;
        tick(10 * FRAME);
        chk("coin_held_released", {24'd0, inp2}, 32'hFF);
        chk("coin_held_one_pulse", coin_pulses - p0, 32'd1);
        chk("coin_held_frames", low_frames - l0, 32'd3);
        joy = 16'h0000;
        tick(SETTLE);

        align_frame();
        p0 = coin_pulses; l0 = low_frames;
        joy = 16'h0800;
        wait_coin(1'b0, SETTLE + 10, ok);
        chk("coin2_start", {31'd0, ok}, 32'd1);
        wait_coin(1'b1, 4 * FRAME, ok);
        chk("coin2_end", {31'd0, ok}, 32'd1);
        joy = 16'h0000;
        tick(SETTLE + 20);
        joy = 16'h0800;
        tick(SETTLE + 20);
        joy = 16'h0000;
        tick(5 * FRAME);
        chk("coin_gap_ignored", coin_pulses - p0, 32'd1);
        align_frame();
        joy = 16'h0800;
        tick(SETTLE + 20);
        joy = 16'h0000;
        tick(5 * FRAME);
        chk("coin_second_pulse", coin_pulses - p0, 32'd2);
        chk("coin_second_frames", low_frames - l0, 32'd6);

        joy = 16'h1000;
        tick(SETTLE);
        joy = 16'h0000;
        tick(SETTLE);
        chk("pause_first", {31'd0, pause_out}, 32'd1);
        joy = 16'h1000;
        tick(3 * SETTLE);
        chk("pause_second_held", {31'd0, pause_out}, 32'd0);
        joy = 16'h0000;
        tick(SETTLE);
        chk("pause_released", {31'd0, pause_out}, 32'd0);

        align_frame();
        joy = 16'h0800;
        wait_coin(1'b0, SETTLE + 10, ok);
        chk("rst_pulse_start", {31'd0, ok}, 32'd1);
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_pulse_inp2", {24'd0, inp2}, 32'hFF);
        tick(2);
        joy = 16'h0000;
        reset_n = 1'b1;
        tick(SETTLE);
        chk("rst_after_inp2", {24'd0, inp2}, 32'hFF);
        chk("rst_after_pause", {31'd0, pause_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
